// File: rtl/logic_op_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : logic_op_checker_if                                              |
// | Brief   : Transaction-in / result-out handshake bundle for the checker.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface logic_op_checker_if #(
  parameter int W1 = 3,
  parameter int W2 = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W1-1:0] in_a;
  logic [W1-1:0] in_a_x;
  logic [W2-1:0] in_b;
  logic [W2-1:0] in_b_x;
  logic [1:0]    in_res;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_exp;
  logic          out_match;

  modport master (
    output in_valid, in_op, in_a, in_a_x, in_b, in_b_x, in_res, out_ready,
    input  in_ready, out_valid, out_exp, out_match
  );

  modport slave (
    input  in_valid, in_op, in_a, in_a_x, in_b, in_b_x, in_res, out_ready,
    output in_ready, out_valid, out_exp, out_match
  );
endinterface
`default_nettype wire

// File: rtl/logic_op_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : logic_op_checker                                                 |
// | Brief   : 2-stage checker for 4-state !, &&, || results with statistics.   |
// |           Macro STRICT_X_EN: expected X matches only an observed X.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module logic_op_checker #(
  parameter int W1    = 3,
  parameter int W2    = 4,
  parameter int CNT_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clear_i,
  logic_op_checker_if.slave      bus,
  output logic [CNT_W-1:0]       pass_cnt_o,
  output logic [CNT_W-1:0]       fail_cnt_o,
  output logic                   first_fail_vld_o,
  output logic [CNT_W-1:0]       first_fail_idx_o
);

  localparam logic [1:0] OP_NOT_A = 2'b00;
  localparam logic [1:0] OP_NOT_B = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  // Truth values encoded {x,val}
  localparam logic [1:0] TRUTH_F = 2'b00;
  localparam logic [1:0] TRUTH_T = 2'b01;
  localparam logic [1:0] TRUTH_X = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: captured transaction
  logic             s1_vld_q, s1_vld_d;
  logic [1:0]       s1_op_q,  s1_op_d;
  logic [W1-1:0]    s1_a_q,   s1_a_d;
  logic [W1-1:0]    s1_ax_q,  s1_ax_d;
  logic [W2-1:0]    s1_b_q,   s1_b_d;
  logic [W2-1:0]    s1_bx_q,  s1_bx_d;
  logic [1:0]       s1_res_q, s1_res_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

  // Stage 2: checked result
  logic             s2_vld_q,   s2_vld_d;
  logic [1:0]       s2_exp_q,   s2_exp_d;
  logic             s2_match_q, s2_match_d;
  logic [CNT_W-1:0] s2_idx_q,   s2_idx_d;

  // Statistics
  logic [CNT_W-1:0] acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0] pass_q,    pass_d;
  logic [CNT_W-1:0] fail_q,    fail_d;
  logic             ff_vld_q,  ff_vld_d;
  logic [CNT_W-1:0] ff_idx_q,  ff_idx_d;

  logic s2_adv, s1_adv, accept, out_hs;
  logic a_true, a_false, b_true, b_false;
  logic [1:0] a_truth, b_truth, exp_w;
  logic obs_x, match_w;

  function automatic logic [1:0] f_not(input logic [1:0] t);
    logic [1:0] r;
    if (t[1])      r = TRUTH_X;
    else if (t[0]) r = TRUTH_F;
    else           r = TRUTH_T;
    return r;
  endfunction

  assign s2_adv = !s2_vld_q || bus.out_ready;
  assign s1_adv = !s1_vld_q || s2_adv;
  assign accept = bus.in_valid && s1_adv;
  assign out_hs = s2_vld_q && bus.out_ready;

  // Unknown bits never make an operand TRUE or FALSE on their own
  always_comb begin
    a_true  = |(s1_a_q & ~s1_ax_q);
    a_false = ~|(s1_a_q | s1_ax_q);
    b_true  = |(s1_b_q & ~s1_bx_q);
    b_false = ~|(s1_b_q | s1_bx_q);
    a_truth = a_true ? TRUTH_T : (a_false ? TRUTH_F : TRUTH_X);
    b_truth = b_true ? TRUTH_T : (b_false ? TRUTH_F : TRUTH_X);
  end

  always_comb begin
    exp_w = TRUTH_X;
    case (s1_op_q)
      OP_NOT_A: exp_w = f_not(a_truth);
      OP_NOT_B: exp_w = f_not(b_truth);
      OP_AND: begin
        if (a_false || b_false)     exp_w = TRUTH_F;
        else if (a_true && b_true)  exp_w = TRUTH_T;
        else                        exp_w = TRUTH_X;
      end
      OP_OR: begin
        if (a_true || b_true)       exp_w = TRUTH_T;
        else if (a_false && b_false) exp_w = TRUTH_F;
        else                        exp_w = TRUTH_X;
      end
      default: exp_w = TRUTH_X;
    endcase
  end

  always_comb begin
    obs_x = s1_res_q[1];
    if (exp_w[1]) begin
`ifdef STRICT_X_EN
      match_w = obs_x;
`else
      match_w = 1'b1;
`endif
    end else begin
      match_w = !obs_x && (s1_res_q[0] == exp_w[0]);
    end
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_ax_d  = s1_ax_q;
    s1_b_d   = s1_b_q;
    s1_bx_d  = s1_bx_q;
    s1_res_d = s1_res_q;
    s1_idx_d = s1_idx_q;
    if (s1_adv) s1_vld_d = bus.in_valid;
    if (accept) begin
      s1_op_d  = bus.in_op;
      s1_a_d   = bus.in_a;
      s1_ax_d  = bus.in_a_x;
      s1_b_d   = bus.in_b;
      s1_bx_d  = bus.in_b_x;
      s1_res_d = bus.in_res;
      s1_idx_d = acc_idx_q;
    end

    s2_vld_d   = s2_vld_q;
    s2_exp_d   = s2_exp_q;
    s2_match_d = s2_match_q;
    s2_idx_d   = s2_idx_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_exp_d   = exp_w;
        s2_match_d = match_w;
        s2_idx_d   = s1_idx_q;
      end
    end
  end

  // A clear swallows any same-cycle result handshake
  always_comb begin
    acc_idx_d = acc_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_vld_d  = ff_vld_q;
    ff_idx_d  = ff_idx_q;
    if (clear_i) begin
      acc_idx_d = '0;
      pass_d    = '0;
      fail_d    = '0;
      ff_vld_d  = 1'b0;
      ff_idx_d  = '0;
    end else begin
      if (accept) acc_idx_d = acc_idx_q + CNT_ONE;
      if (out_hs) begin
        if (s2_match_q) begin
          if (pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
        end else begin
          if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
          if (!ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_idx_d = s2_idx_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_ax_q    <= '0;
      s1_b_q     <= '0;
      s1_bx_q    <= '0;
      s1_res_q   <= '0;
      s1_idx_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_exp_q   <= '0;
      s2_match_q <= 1'b0;
      s2_idx_q   <= '0;
      acc_idx_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_vld_q   <= 1'b0;
      ff_idx_q   <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_ax_q    <= s1_ax_d;
      s1_b_q     <= s1_b_d;
      s1_bx_q    <= s1_bx_d;
      s1_res_q   <= s1_res_d;
      s1_idx_q   <= s1_idx_d;
      s2_vld_q   <= s2_vld_d;
      s2_exp_q   <= s2_exp_d;
      s2_match_q <= s2_match_d;
      s2_idx_q   <= s2_idx_d;
      acc_idx_q  <= acc_idx_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_vld_q   <= ff_vld_d;
      ff_idx_q   <= ff_idx_d;
    end
  end

  assign bus.in_ready      = s1_adv;
  assign bus.out_valid     = s2_vld_q;
  assign bus.out_exp       = s2_exp_q;
  assign bus.out_match     = s2_match_q;
  assign pass_cnt_o        = pass_q;
  assign fail_cnt_o        = fail_q;
  assign first_fail_vld_o  = ff_vld_q;
  assign first_fail_idx_o  = ff_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_logic_op_checker                                              |
// | Brief   : Randomised self-checking bench with a truth-value scoreboard.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_logic_op_checker;
  localparam int W1 = 3;
  localparam int W2 = 4;
  localparam int CNT_W = 4;
  localparam int TF = 0, TT = 1, TX = 2;

  typedef struct {
    logic [1:0]    op;
    logic [W1-1:0] a, ax;
    logic [W2-1:0] b, bx;
    logic [1:0]    res;
  } txn_t;

  typedef struct {
    logic [1:0]       e;
    bit               mt;
    logic [CNT_W-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, ffi;
  logic ffv;
  int tests = 0, fails = 0, pops = 0;

  always #5 clk = ~clk;

  logic_op_checker_if #(.W1(W1), .W2(W2)) bus ();

  logic_op_checker #(.W1(W1), .W2(W2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .bus(bus),
    .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt),
    .first_fail_vld_o(ffv), .first_fail_idx_o(ffi)
  );

  // ---------------- reference model ----------------
  function automatic int truth(input logic [7:0] v, input logic [7:0] xm, input int w);
    bit any1 = 0, anyx = 0;
    for (int i = 0; i < w; i++) begin
      if (xm[i]) anyx = 1;
      else if (v[i]) any1 = 1;
    end
    return any1 ? TT : (anyx ? TX : TF);
  endfunction

  function automatic int lnot(input int t);
    return (t == TT) ? TF : ((t == TF) ? TT : TX);
  endfunction

  function automatic int expect_of(input txn_t t);
    int ta = truth(8'(t.a), 8'(t.ax), W1);
    int tb = truth(8'(t.b), 8'(t.bx), W2);
    case (t.op)
      2'd0: return lnot(ta);
      2'd1: return lnot(tb);
      2'd2: return (ta == TF || tb == TF) ? TF : ((ta == TT && tb == TT) ? TT : TX);
      default: return (ta == TT || tb == TT) ? TT : ((ta == TF && tb == TF) ? TF : TX);
    endcase
  endfunction

  function automatic logic [1:0] enc(input int t);
    return (t == TT) ? 2'b01 : ((t == TF) ? 2'b00 : 2'b10);
  endfunction

  function automatic bit match_of(input int e, input logic [1:0] res);
    int o = res[1] ? TX : (res[0] ? TT : TF);
    if (e == TX) begin
`ifdef STRICT_X_EN
      return (o == TX);
`else
      return 1'b1;
`endif
    end
    return (o == e);
  endfunction

  // kind 0: random, 1: forced match, 2: forced mismatch (known operands)
  function automatic txn_t gen_txn(input int kind);
    txn_t t;
    logic [1:0] ev;
    t.op = 2'($urandom);
    t.a  = W1'($urandom);
    t.b  = W2'($urandom);
    t.ax = ($urandom_range(0, 99) < 40) ? W1'($urandom) : '0;
    t.bx = ($urandom_range(0, 99) < 40) ? W2'($urandom) : '0;
    if (kind == 2) begin
      t.ax = '0;
      t.bx = '0;
    end
    ev = enc(expect_of(t));
    if (kind == 1)      t.res = ev;
    else if (kind == 2) t.res = {1'b0, ~ev[0]};
    else                t.res = ($urandom_range(0, 99) < 70) ? ev : 2'($urandom);
    return t;
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t exp_q[$];
  logic [CNT_W-1:0] pass_m = '0, fail_m = '0, ffi_m = '0, idx_m = '0;
  bit ffv_m = 0;
  bit prev_stall = 0;
  logic [1:0] prev_exp = '0;
  logic prev_match = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      pass_m = '0; fail_m = '0; ffi_m = '0; idx_m = '0; ffv_m = 0;
      prev_stall = 0;
    end else begin
      tests++;
      if (pass_cnt !== pass_m || fail_cnt !== fail_m || ffv !== ffv_m || ffi !== ffi_m) begin
        fails++;
        $display("FAIL stats: got pass=%0d fail=%0d ffv=%0b ffi=%0d, want pass=%0d fail=%0d ffv=%0b ffi=%0d",
                 pass_cnt, fail_cnt, ffv, ffi, pass_m, fail_m, ffv_m, ffi_m);
      end
      if (prev_stall) begin
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_exp !== prev_exp || bus.out_match !== prev_match) begin
          fails++;
          $display("FAIL hold: got v=%b exp=%b m=%b, want v=1 exp=%b m=%b",
                   bus.out_valid, bus.out_exp, bus.out_match, prev_exp, prev_match);
        end
      end
      if (bus.out_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL order: got unexpected out_exp=%b, want no output", bus.out_exp);
        end else begin
          if (bus.out_exp !== exp_q[0].e || bus.out_match !== exp_q[0].mt) begin
            fails++;
            $display("FAIL result: got exp=%b match=%b, want exp=%b match=%b",
                     bus.out_exp, bus.out_match, exp_q[0].e, exp_q[0].mt);
          end
          if (bus.out_ready) begin
            if (!clear) begin
              if (exp_q[0].mt) begin
                if (pass_m != '1) pass_m++;
              end else begin
                if (fail_m != '1) fail_m++;
                if (!ffv_m) begin ffv_m = 1; ffi_m = exp_q[0].idx; end
              end
            end
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (clear) begin
        pass_m = '0; fail_m = '0; ffv_m = 0; ffi_m = '0;
      end
      if (bus.in_valid && bus.in_ready) begin
        txn_t t;
        exp_t x;
        int ev;
        t.op = bus.in_op; t.a = bus.in_a; t.ax = bus.in_a_x;
        t.b = bus.in_b; t.bx = bus.in_b_x; t.res = bus.in_res;
        ev = expect_of(t);
        x.e = enc(ev); x.mt = match_of(ev, t.res); x.idx = idx_m;
        exp_q.push_back(x);
        if (!clear) idx_m++;
      end
      if (clear) idx_m = '0;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_exp   = bus.out_exp;
      prev_match = bus.out_match;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic drive(input txn_t t);
    bus.in_op = t.op; bus.in_a = t.a; bus.in_a_x = t.ax;
    bus.in_b = t.b; bus.in_b_x = t.bx; bus.in_res = t.res;
  endtask

  task automatic send(input txn_t t);
    bit acc = 0;
    drive(t);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.out_valid === 1'b1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic stream(input int n, input int kind, input int vprob, input int rprob,
                        input bit stall, output bit saw_block);
    int sent = 0, guard = 0, p0 = pops;
    bit acc = 0;
    saw_block = 0;
    while ((sent < n || (pops - p0) < n) && guard < 5000) begin
      if (!bus.in_valid || acc) begin
        if (sent < n && $urandom_range(0, 99) < vprob) begin
          drive(gen_txn(kind));
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = stall ? !(guard >= 3 && guard <= 5) : ($urandom_range(0, 99) < rprob);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready) saw_block = 1;
      if (acc) sent++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  function automatic txn_t mk(input logic [1:0] op, input logic [W1-1:0] a, input logic [W1-1:0] ax,
                              input logic [W2-1:0] b, input logic [W2-1:0] bx, input logic [1:0] res);
    txn_t t;
    t.op = op; t.a = a; t.ax = ax; t.b = b; t.bx = bx; t.res = res;
    return t;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_exp !== 2'b00 ||
        bus.out_match !== 1'b0 || pass_cnt !== '0 || fail_cnt !== '0 || ffv !== 1'b0 || ffi !== '0) begin
      fails++;
      $display("FAIL reset: got rdy=%b v=%b exp=%b m=%b pass=%0d fail=%0d ffv=%b ffi=%0d, want 1 0 00 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_exp, bus.out_match, pass_cnt, fail_cnt, ffv, ffi);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    txn_t tv[10];
    logic [1:0] ee[10];
    bit mm[10];
    bit ok;
    tv[0] = mk(2'b00, 3'b111, 3'b000, 4'b0000, 4'b0000, 2'b00); ee[0] = 2'b00; mm[0] = 1;
    tv[1] = mk(2'b01, 3'b000, 3'b000, 4'b0000, 4'b0000, 2'b01); ee[1] = 2'b01; mm[1] = 1;
    tv[2] = mk(2'b10, 3'b111, 3'b000, 4'b0000, 4'b0000, 2'b00); ee[2] = 2'b00; mm[2] = 1;
    tv[3] = mk(2'b11, 3'b111, 3'b000, 4'b0000, 4'b0000, 2'b01); ee[3] = 2'b01; mm[3] = 1;
    tv[4] = mk(2'b00, 3'b000, 3'b001, 4'b0000, 4'b0000, 2'b10); ee[4] = 2'b10; mm[4] = 1;
    tv[5] = mk(2'b11, 3'b000, 3'b001, 4'b0000, 4'b0000, 2'b10); ee[5] = 2'b10; mm[5] = 1;
    tv[6] = mk(2'b10, 3'b000, 3'b001, 4'b0000, 4'b0000, 2'b00); ee[6] = 2'b00; mm[6] = 1;
    tv[7] = mk(2'b10, 3'b100, 3'b000, 4'b0010, 4'b0100, 2'b01); ee[7] = 2'b01; mm[7] = 1;
    tv[8] = mk(2'b01, 3'b000, 3'b000, 4'b1111, 4'b1111, 2'b10); ee[8] = 2'b10; mm[8] = 1;
    tv[9] = mk(2'b10, 3'b010, 3'b000, 4'b0001, 4'b0000, 2'b00); ee[9] = 2'b01; mm[9] = 0;
    bus.out_ready = 1'b1;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      send(tv[i]);
      wait_out(ok);
      tests++;
      if (!ok || bus.out_exp !== ee[i] || bus.out_match !== mm[i]) begin
        fails++;
        $display("FAIL truth[%0d]: got v=%b exp=%b match=%b, want v=1 exp=%b match=%b",
                 i, ok, bus.out_exp, bus.out_match, ee[i], mm[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin
        tests++;
        if (pass_cnt !== 4'd1) begin
          fails++;
          $display("FAIL first_pass: got pass=%0d, want 1", pass_cnt);
        end
      end
    end
    tests++;
    if (pass_cnt !== 4'd9 || fail_cnt !== 4'd1 || ffv !== 1'b1 || ffi !== 4'd9) begin
      fails++;
      $display("FAIL truth_stats: got pass=%0d fail=%0d ffv=%b ffi=%0d, want 9 1 1 9",
               pass_cnt, fail_cnt, ffv, ffi);
    end
  endtask

  task automatic test_strict_x();
    bit ok;
    bit want_m;
`ifdef STRICT_X_EN
    want_m = 0;
`else
    want_m = 1;
`endif
    do_clear();
    send(mk(2'b00, 3'b000, 3'b001, 4'b0000, 4'b0000, 2'b01));
    wait_out(ok);
    tests++;
    if (!ok || bus.out_exp !== 2'b10 || bus.out_match !== want_m) begin
      fails++;
      $display("FAIL strict_x: got v=%b exp=%b match=%b, want v=1 exp=10 match=%b",
               ok, bus.out_exp, bus.out_match, want_m);
    end
    @(posedge clk); #1;
    tests++;
    if (fail_cnt !== (want_m ? 4'd0 : 4'd1) || pass_cnt !== (want_m ? 4'd1 : 4'd0) ||
        ffv !== !want_m || ffi !== 4'd0) begin
      fails++;
      $display("FAIL strict_x_stats: got pass=%0d fail=%0d ffv=%b ffi=%0d, want pass=%0d fail=%0d ffv=%b ffi=0",
               pass_cnt, fail_cnt, ffv, ffi, want_m, !want_m, !want_m);
    end
  endtask

  task automatic test_random();
    bit blk;
    int p0 = pops;
    do_clear();
    stream(300, 0, 70, 70, 0, blk);
    tests++;
    if ((pops - p0) != 300 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL random_drain: got outputs=%0d pending=%0d, want 300 0", pops - p0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit blk;
    int p0 = pops;
    do_clear();
    stream(6, 1, 100, 100, 1, blk);
    tests++;
    if (!blk || (pops - p0) != 6 || exp_q.size() != 0 || pass_cnt !== 4'd6) begin
      fails++;
      $display("FAIL back_to_back: got blocked=%b outputs=%0d pending=%0d pass=%0d, want 1 6 0 6",
               blk, pops - p0, exp_q.size(), pass_cnt);
    end
  endtask

  task automatic test_saturation();
    bit blk;
    do_clear();
    stream(18, 1, 100, 100, 0, blk);
    tests++;
    if (pass_cnt !== 4'd15) begin
      fails++;
      $display("FAIL pass_sat: got pass=%0d, want 15", pass_cnt);
    end
    stream(17, 2, 100, 100, 0, blk);
    tests++;
    if (fail_cnt !== 4'd15 || pass_cnt !== 4'd15 || ffv !== 1'b1 || ffi !== 4'd2) begin
      fails++;
      $display("FAIL fail_sat: got pass=%0d fail=%0d ffv=%b ffi=%0d, want 15 15 1 2",
               pass_cnt, fail_cnt, ffv, ffi);
    end
  endtask

  task automatic test_clear();
    bit ok;
    bus.out_ready = 1'b1;
    send(mk(2'b00, 3'b111, 3'b000, 4'b0000, 4'b0000, 2'b00));
    wait_out(ok);
    @(posedge clk); #1;
    send(mk(2'b10, 3'b010, 3'b000, 4'b0001, 4'b0000, 2'b00));
    wait_out(ok);
    @(posedge clk); #1;
    send(mk(2'b00, 3'b111, 3'b000, 4'b0000, 4'b0000, 2'b00));
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_exp !== 2'b00) begin
      fails++;
      $display("FAIL clear_present: got v=%b exp=%b, want v=1 exp=00", bus.out_valid, bus.out_exp);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    tests++;
    if (pass_cnt !== '0 || fail_cnt !== '0 || ffv !== 1'b0 || ffi !== '0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_hs: got pass=%0d fail=%0d ffv=%b ffi=%0d v=%b, want 0 0 0 0 0",
               pass_cnt, fail_cnt, ffv, ffi, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.out_ready = 1'b1;
    send(mk(2'b01, 3'b000, 3'b000, 4'b0000, 4'b0000, 2'b01));
    wait_out(ok);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(mk(2'b11, 3'b001, 3'b000, 4'b0000, 4'b0000, 2'b01));
    send(mk(2'b10, 3'b001, 3'b000, 4'b0000, 4'b0000, 2'b00));
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || pass_cnt === '0) begin
      fails++;
      $display("FAIL pre_reset: got v=%b rdy=%b pass=%0d, want v=1 rdy=0 pass>0",
               bus.out_valid, bus.in_ready, pass_cnt);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || pass_cnt !== '0 || fail_cnt !== '0 ||
        ffv !== 1'b0 || bus.out_exp !== 2'b00) begin
      fails++;
      $display("FAIL async_reset: got v=%b rdy=%b pass=%0d fail=%0d ffv=%b exp=%b, want 0 1 0 0 0 00",
               bus.out_valid, bus.in_ready, pass_cnt, fail_cnt, ffv, bus.out_exp);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(mk(2'b11, 3'b000, 3'b000, 4'b0000, 4'b0000, 2'b00));
    wait_out(ok);
    tests++;
    if (!ok || bus.out_exp !== 2'b00 || bus.out_match !== 1'b1) begin
      fails++;
      $display("FAIL post_reset: got v=%b exp=%b match=%b, want v=1 exp=00 match=1",
               ok, bus.out_exp, bus.out_match);
    end
    @(posedge clk); #1;
    tests++;
    if (pass_cnt !== 4'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL post_reset_cnt: got pass=%0d pending=%0d, want 1 0", pass_cnt, exp_q.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_a_x = '0;
    bus.in_b = '0; bus.in_b_x = '0; bus.in_res = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_truth_table();
    test_strict_x();
    test_random();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
